// File: rtl/bp_me_stream_demux.sv
// Routes whole BedRock Stream packets from one input to one of num_sink_p sinks. Beats pass through a two-entry input FIFO.
// Latency is 1 cycle from accept to output, at 1 beat/cycle. A stalled selected sink holds the head; ready drops when the FIFO fills.
module bp_me_stream_demux #(
    parameter int header_width_p = 66,
    parameter int data_width_p   = 64,
    parameter int num_sink_p     = 3,
    localparam int lg_num_sink_lp   = (num_sink_p > 1) ? $clog2(num_sink_p) : 1,
    localparam int lg_data_bytes_lp = $clog2(data_width_p / 8)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [header_width_p-1:0]                   msg_header_i,
    input  logic [data_width_p-1:0]                     msg_data_i,
    input  logic [2:0]                                  msg_size_i,
    input  logic                                        msg_has_data_i,
    input  logic [lg_num_sink_lp-1:0]                   msg_dst_i,
    input  logic                                        msg_v_i,
    output logic                                        msg_ready_and_o,
    output logic [num_sink_p-1:0][header_width_p-1:0]   msg_header_o,
    output logic [num_sink_p-1:0][data_width_p-1:0]     msg_data_o,
    output logic [num_sink_p-1:0]                       msg_v_o,
    input  logic [num_sink_p-1:0]                       msg_ready_and_i,
    output logic                                        error_o,
    output logic                                        busy_o
);
    localparam int cnt_w_lp = $clog2(128 / (data_width_p / 8)) + 1;

    typedef struct packed {
        logic [lg_num_sink_lp-1:0] dst;
        logic [2:0]                size;
        logic                      has_data;
        logic [header_width_p-1:0] header;
        logic [data_width_p-1:0]   data;
    } beat_t;

    typedef enum logic {IDLE, BUSY} state_e;

    beat_t       mem [2];
    beat_t       in_beat, head;
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count, count_next;
    logic        ready_r;
    logic        enq, deq, head_v;

    state_e                    state_r, state_n;
    logic [cnt_w_lp-1:0]       cnt_r, cnt_n, beats;
    logic [lg_num_sink_lp-1:0] dst_r, dst_n, cur_dst;
    logic [7:0]                pkt_bytes, beat_raw;
    logic                      drop, last, sel_ready;

    assign in_beat = '{dst: msg_dst_i, size: msg_size_i, has_data: msg_has_data_i,
                       header: msg_header_i, data: msg_data_i};
    assign enq     = msg_v_i & ready_r;
    assign head_v  = (count != 2'd0);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (enq && !deq)
            count_next = count + 2'd1;
        else if (!enq && deq)
            count_next = count - 2'd1;
    end

    // Ready is the registered not-full of the next cycle, so it never admits a beat into a full FIFO.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            count   <= count_next;
            ready_r <= (count_next != 2'd2);
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr] <= in_beat;
    end

    // Packet length from the head's first-beat fields; sub-beat payloads still take one beat.
    always_comb begin
        pkt_bytes = 8'd1 << head.size;
        beat_raw  = pkt_bytes >> lg_data_bytes_lp;
        beats     = cnt_w_lp'(1);
        if (head.has_data && beat_raw != 8'd0)
            beats = cnt_w_lp'(beat_raw);
    end

    always_comb begin
        cur_dst   = (state_r == BUSY) ? dst_r : head.dst;
        drop      = (int'(cur_dst) >= num_sink_p);
        sel_ready = drop;
        for (int i = 0; i < num_sink_p; i++) begin
            if (int'(cur_dst) == i) sel_ready = msg_ready_and_i[i];
        end
        deq  = head_v & sel_ready;
        last = (state_r == BUSY) ? (cnt_r == cnt_w_lp'(1)) : (beats == cnt_w_lp'(1));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            dst_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            dst_r   <= dst_n;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        dst_n   = dst_r;
        if (deq) begin
            case (state_r)
                IDLE: begin
                    if (beats != cnt_w_lp'(1)) begin
                        state_n = BUSY;
                        cnt_n   = beats - cnt_w_lp'(1);
                        dst_n   = head.dst;
                    end
                end
                BUSY: begin
                    cnt_n = cnt_r - cnt_w_lp'(1);
                    if (cnt_r == cnt_w_lp'(1)) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < num_sink_p; i++) begin
            msg_v_o[i] = head_v & ~drop & (int'(cur_dst) == i);
        end
        msg_ready_and_o = ready_r;
        msg_header_o    = {num_sink_p{head.header}};
        msg_data_o      = {num_sink_p{head.data}};
        error_o         = deq & drop & last;
        busy_o          = (state_r == BUSY);
    end

endmodule

// File: tb/tb_bp_me_stream_demux.sv
// Directed bench for bp_me_stream_demux: routing, locking, stall, drop and async reset.
module tb_bp_me_stream_demux;
    localparam int hw = 66;
    localparam int dw = 64;
    localparam int ns = 3;

    logic                   clk_i = 1'b0;
    logic                   reset_n_i;
    logic [hw-1:0]          msg_header_i;
    logic [dw-1:0]          msg_data_i;
    logic [2:0]             msg_size_i;
    logic                   msg_has_data_i;
    logic [1:0]             msg_dst_i;
    logic                   msg_v_i;
    logic                   msg_ready_and_o;
    logic [ns-1:0][hw-1:0]  msg_header_o;
    logic [ns-1:0][dw-1:0]  msg_data_o;
    logic [ns-1:0]          msg_v_o;
    logic [ns-1:0]          msg_ready_and_i;
    logic                   error_o;
    logic                   busy_o;

    typedef struct {
        int          sink;
        logic [63:0] dat;
    } rx_t;

    rx_t rxq[$];
    int  n_vec    = 0;
    int  n_err    = 0;
    int  err_seen = 0;

    bp_me_stream_demux #(.header_width_p(hw), .data_width_p(dw), .num_sink_p(ns)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .msg_header_i(msg_header_i), .msg_data_i(msg_data_i), .msg_size_i(msg_size_i),
        .msg_has_data_i(msg_has_data_i), .msg_dst_i(msg_dst_i), .msg_v_i(msg_v_i),
        .msg_ready_and_o(msg_ready_and_o), .msg_header_o(msg_header_o), .msg_data_o(msg_data_o),
        .msg_v_o(msg_v_o), .msg_ready_and_i(msg_ready_and_i), .error_o(error_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        for (int i = 0; i < ns; i++) begin
            if (msg_v_o[i] && msg_ready_and_i[i]) rxq.push_back('{sink: i, dat: msg_data_o[i]});
        end
        if (error_o) err_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] d, input logic [2:0] sz, input logic hd, input logic [63:0] dat);
        msg_dst_i      = d;
        msg_size_i     = sz;
        msg_has_data_i = hd;
        msg_data_i     = dat;
        msg_header_i   = {2'b10, ~dat};
        msg_v_i        = 1'b1;
    endtask

    task automatic expect_rx(input string tag, input int sink, input logic [63:0] dat);
        rx_t r;
        chk({tag, "_avail"}, rxq.size() != 0, 1);
        if (rxq.size() != 0) begin
            r = rxq.pop_front();
            chk({tag, "_sink"}, r.sink, sink);
            chk({tag, "_dat"}, r.dat, dat);
        end
    endtask

    // Streams n beats back to back (sinks ready), checking the head each cycle.
    task automatic stream(input string tag, input logic [1:0] d0, input logic [1:0] dn,
                          input logic [2:0] sz, input int n, input logic [63:0] base,
                          input logic [2:0] ev, input bit tail);
        drive(d0, sz, 1'b1, base);
        for (int j = 0; j <= n; j++) begin
            @(posedge clk_i); #1;
            if (j + 1 < n) drive(dn, sz, 1'b1, base + 64'(j + 1));
            else if (j + 1 == n && tail) drive(2'd0, 3'd3, 1'b1, 64'h100);
            else msg_v_i = 1'b0;
            if (j < n) begin
                chk({tag, "_v"}, msg_v_o, ev);
                chk({tag, "_dat"}, msg_data_o[0], base + 64'(j));
                chk({tag, "_busy"}, busy_o, (n > 1 && j > 0));
                chk({tag, "_err"}, error_o, (ev == 3'b000 && j == n - 1));
            end else begin
                chk({tag, "_busy_end"}, busy_o, 1'b0);
                chk({tag, "_v_end"}, msg_v_o, tail ? 3'b001 : 3'b000);
            end
        end
        if (tail) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        int  nxt;
        bit  acc;
        reset_n_i       = 1'b0;
        msg_v_i         = 1'b0;
        msg_ready_and_i = 3'b111;
        drive(2'd0, 3'd0, 1'b0, 64'h0);
        msg_v_i         = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_v", msg_v_o, 3'b000);
        chk("rst_rdy", msg_ready_and_o, 1'b0);
        chk("rst_err", error_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        @(negedge clk_i) reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rdy_up", msg_ready_and_o, 1'b1);

        // Single-beat packet to sink 1
        drive(2'd1, 3'd3, 1'b1, 64'hA5);
        @(posedge clk_i); #1;
        msg_v_i = 1'b0;
        chk("one_v", msg_v_o, 3'b010);
        chk("one_dat", msg_data_o[1], 64'hA5);
        chk("one_hdr", msg_header_o[1], 66'h2_FFFF_FFFF_FFFF_FF5A);
        chk("one_busy", busy_o, 1'b0);
        @(posedge clk_i); #1;
        chk("one_busy2", busy_o, 1'b0);
        chk("one_v_end", msg_v_o, 3'b000);
        expect_rx("one_rx", 1, 64'hA5);

        // 8-beat packet to sink 2, then a 1-beat packet to sink 0 with no bubble
        stream("burst", 2'd2, 2'd2, 3'd6, 8, 64'h0, 3'b100, 1'b1);
        for (int k = 0; k < 8; k++) expect_rx("burst_rx", 2, 64'(k));
        expect_rx("burst_tail", 0, 64'h100);
        chk("burst_left", rxq.size(), 0);

        // Destination locked for the whole packet despite dst toggling
        stream("lock", 2'd0, 2'd1, 3'd6, 8, 64'h10, 3'b001, 1'b0);
        for (int k = 0; k < 8; k++) expect_rx("lock_rx", 0, 64'h10 + 64'(k));
        chk("lock_left", rxq.size(), 0);

        // Sink 0 stalls for 5 edges during a 4-beat packet
        msg_ready_and_i = 3'b110;
        nxt = 0;
        drive(2'd0, 3'd5, 1'b1, 64'h40);
        for (int c = 0; c < 12; c++) begin
            acc = msg_v_i & msg_ready_and_o;
            @(posedge clk_i); #1;
            if (acc) nxt++;
            if (nxt < 4) drive(2'd1, 3'd5, 1'b1, 64'h40 + 64'(nxt));
            else msg_v_i = 1'b0;
            if (c == 4) msg_ready_and_i = 3'b111;
            if (c <= 4) begin
                chk("stall_v", msg_v_o, 3'b001);
                chk("stall_dat", msg_data_o[0], 64'h40);
            end
            if (c == 1) chk("stall_rdy_low", msg_ready_and_o, 1'b0);
            if (c == 5) chk("stall_rdy_up", msg_ready_and_o, 1'b1);
        end
        for (int k = 0; k < 4; k++) expect_rx("stall_rx", 0, 64'h40 + 64'(k));
        chk("stall_left", rxq.size(), 0);

        // Packet to nonexistent sink 3 is drained and flagged once
        stream("drop", 2'd3, 2'd3, 3'd5, 4, 64'h20, 3'b000, 1'b0);
        chk("drop_errcnt", err_seen, 1);
        chk("drop_left", rxq.size(), 0);

        // Asynchronous reset mid-packet
        drive(2'd1, 3'd6, 1'b1, 64'h30);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk_i); #1;
            if (j < 3) drive(2'd1, 3'd6, 1'b1, 64'h31 + 64'(j));
            else msg_v_i = 1'b0;
        end
        chk("mid_v", msg_v_o, 3'b010);
        chk("mid_busy", busy_o, 1'b1);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_v", msg_v_o, 3'b000);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_rdy", msg_ready_and_o, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        drive(2'd1, 3'd3, 1'b1, 64'hBEEF);
        @(posedge clk_i); #1;
        msg_v_i = 1'b0;
        chk("post_v", msg_v_o, 3'b010);
        chk("post_dat", msg_data_o[1], 64'hBEEF);
        chk("post_busy", busy_o, 1'b0);
        @(posedge clk_i); #1;
        chk("post_v_end", msg_v_o, 3'b000);
        chk("post_errcnt", err_seen, 1);
        for (int k = 0; k < 3; k++) expect_rx("mid_rx", 1, 64'h30 + 64'(k));
        expect_rx("post_rx", 1, 64'hBEEF);
        chk("post_left", rxq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
